// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one 2-bit ALU between four
// requesters. Each accepted operation goes IDLE -> EXEC -> RESP, so one
// result is produced at most every three cycles.
// The optional operation counter is built when ALU_ARBITER_STATS_EN is defined.
module alu_arbiter #(
  parameter int NUM_REQ = 4  // only 4 requesters are supported (2-bit ids)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*NUM_REQ-1:0]   req_a,
  input  logic [2*NUM_REQ-1:0]   req_b,
  input  logic [3*NUM_REQ-1:0]   req_sel,
  output logic [1:0]             alu_a,
  output logic [1:0]             alu_b,
  output logic [2:0]             alu_sel,
  input  logic [2:0]             alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic [2:0]             rsp_data,
  output logic                   busy
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [7:0]             op_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_rr_ptr;
  logic [1:0] r_gnt_id;
  logic [1:0] r_a;
  logic [1:0] r_b;
  logic [2:0] r_sel;
  logic [1:0] r_rsp_id;
  logic [2:0] r_rsp_data;
  logic [1:0] w_gnt_id;
  logic [1:0] w_idx;
  logic       w_found;
  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [2:0] w_sel;
  logic       w_accept;
  logic       w_rsp_done;

  // Search upward from the round-robin pointer for the first valid requester
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  // Grant only in IDLE and never while reset is held, even if requests are up
  assign req_ready  = (r_state == IDLE && rst_n && w_found) ? (NUM_REQ'(1) << w_gnt_id) : '0;
  assign w_accept   = |(req_valid & req_ready);
  assign w_rsp_done = (r_state == RESP) && rsp_ready;

  // Pick the winning requester's operands out of the packed buses
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == 2'(i)) begin
        w_a   = req_a[2*i +: 2];
        w_b   = req_b[2*i +: 2];
        w_sel = req_sel[3*i +: 3];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: one cycle of execution, then hold in RESP until consumed
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand latch on accept, result capture at end of EXEC, pointer advance on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sel      <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= w_a;
        r_b      <= w_b;
        r_sel    <= w_sel;
        r_gnt_id <= w_gnt_id;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= alu_out;
        r_rsp_id   <= r_gnt_id;
      end
      if (w_rsp_done) r_rr_ptr <= r_gnt_id + 2'd1;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);

`ifdef ALU_ARBITER_STATS_EN
  logic [7:0] r_op_count;

  // Saturating count of completed response handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_op_count <= '0;
    else if (w_rsp_done && r_op_count != 8'hFF) r_op_count <= r_op_count + 8'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter. A reference arbiter model
// predicts each grant and pushes the expected {id, result} when the request is
// accepted; the entry is compared while the response is presented and popped
// on the handshake. Build with ALU_ARBITER_STATS_EN to also cover op_count.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [11:0] req_sel;
  logic [1:0]  alu_a;
  logic [1:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [2:0]  alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_data;
  logic        busy;
`ifdef ALU_ARBITER_STATS_EN
  logic [7:0]  op_count;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  int         cyc = 0;
  int         mState = 0;
  logic [1:0] mPtr, mGnt, mA, mB, mId;
  logic [2:0] mSel;
  logic [3:0] mExpReady;
  logic [4:0] mFront;
  int         mOps = 0;
  logic [4:0] sb[$];
  int         gntLog[$];
  int         gntCyc[$];
  int         expOrder[5] = '{0, 1, 2, 3, 0};
  logic [2:0] expData;

  alu_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
`ifdef ALU_ARBITER_STATS_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  // shared 2-bit arithmetic unit with a signed 3-bit result
  function automatic logic [2:0] aluModel(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s);
    case (s)
      3'b000:  aluModel = {1'b0, a} + {1'b0, b};
      3'b001:  aluModel = {1'b0, a} - {1'b0, b};
      3'b010:  aluModel = {1'b0, a & b};
      3'b011:  aluModel = {1'b0, a | b};
      3'b100:  aluModel = {1'b0, a ^ b};
      3'b101:  aluModel = {a[1], a};
      3'b110:  aluModel = {a, 1'b0};
      default: aluModel = 3'b000 - {1'b0, a};
    endcase
  endfunction

  assign alu_out = aluModel(alu_a, alu_b, alu_sel);

  // expected one-hot grant: first valid index at or after the pointer, modulo 4
  function automatic logic [3:0] rrPick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rrPick = '0;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && v[idx]) begin
        found  = 1'b1;
        rrPick = 4'b0001 << idx;
      end
    end
  endfunction

  function automatic logic [1:0] onehotToIdx(input logic [3:0] oh);
    onehotToIdx = '0;
    for (int k = 0; k < 4; k++) if (oh[k]) onehotToIdx = 2'(k);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                               input logic [11:0] s, input logic rr);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_sel   = s;
    rsp_ready = rr;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_sel", alu_sel, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_busy", busy, 0);
  endtask

  // one full operation with random operands, response consumed immediately
  task automatic doOp(input logic [3:0] v);
    applyStimulus(v, 8'($urandom), 8'($urandom), 12'($urandom), 1'b1);
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  // cycle-by-cycle reference model and scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mState = 0;
      mPtr   = '0;
      mGnt   = '0;
      mA     = '0;
      mB     = '0;
      mSel   = '0;
      mOps   = 0;
      sb.delete();
      checkOutput("rst_rsp_valid_hold", rsp_valid, 0);
      checkOutput("rst_req_ready_hold", req_ready, 0);
    end else begin
      mExpReady = (mState == 0) ? rrPick(req_valid, mPtr) : 4'b0000;
      checkOutput("req_ready", req_ready, mExpReady);
      checkOutput("busy", busy, (mState != 0));
      checkOutput("rsp_valid", rsp_valid, (mState == 2));
      checkOutput("alu_ops", {alu_a, alu_b, alu_sel}, {mA, mB, mSel});
`ifdef ALU_ARBITER_STATS_EN
      checkOutput("op_count", op_count, mOps);
`endif
      case (mState)
        0: if (mExpReady != 4'b0000) begin
             mId  = onehotToIdx(mExpReady);
             mA   = req_a[2*mId +: 2];
             mB   = req_b[2*mId +: 2];
             mSel = req_sel[3*mId +: 3];
             mGnt = mId;
             sb.push_back({mId, aluModel(mA, mB, mSel)});
             gntLog.push_back(int'(mId));
             gntCyc.push_back(cyc);
             mState = 1;
           end
        1: mState = 2;
        default: begin
          if (sb.size() == 0) begin
            checkOutput("sb_underflow", 1, 0);
          end else begin
            mFront = sb[0];
            checkOutput("rsp_id", rsp_id, mFront[4:3]);
            checkOutput("rsp_data", rsp_data, mFront[2:0]);
          end
          if (rsp_ready) begin
            if (sb.size() != 0) void'(sb.pop_front());
            mPtr = mGnt + 2'd1;
            if (mOps < 255) mOps++;
            mState = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b1111, 8'hFF, 8'hFF, 12'hFFF, 1'b1);
    #12;
    checkResetOutputs();

    // continuous pressure from all four requesters
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gntLog.delete();
    gntCyc.delete();
    applyStimulus(4'b1111, 8'($urandom), 8'($urandom), 12'($urandom), 1'b1);
    for (int i = 0; i < 13; i++) tick();
    req_valid = '0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("rr_grant_count", gntLog.size(), 5);
    for (int i = 0; i < 5 && i < gntLog.size(); i++) begin
      checkOutput($sformatf("rr_order%0d", i), gntLog[i], expOrder[i]);
      if (i > 0) checkOutput($sformatf("rr_gap%0d", i), gntCyc[i] - gntCyc[i-1], 3);
    end

    // single request: 2 + 2 on opcode 000
    applyStimulus(4'b0001, 8'b0000_0010, 8'b0000_0010, 12'h000, 1'b1);
    @(negedge clk);
    checkOutput("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    checkOutput("single_rsp_valid", rsp_valid, 1);
    checkOutput("single_rsp_id", rsp_id, 0);
    checkOutput("single_rsp_data", rsp_data, 3'b100);
    tick();

    // pointer resume: serve requester 2, then 0 wins over 2 via wrap
    doOp(4'b0100);
    applyStimulus(4'b0101, 8'($urandom), 8'($urandom), 12'($urandom), 1'b1);
    @(negedge clk);
    checkOutput("ptr_wrap_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();

    // response stall on requester 1 with all others pushing
    applyStimulus(4'b0010, 8'b0000_1100, 8'b0000_0100, 12'b000_000_001_000, 1'b0);
    expData = aluModel(2'b11, 2'b01, 3'b001);
    @(negedge clk);
    checkOutput("stall_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_rsp_valid", rsp_valid, 1);
      checkOutput("stall_req_ready", req_ready, 4'b0000);
      checkOutput("stall_rsp_id", rsp_id, 1);
      checkOutput("stall_rsp_data", rsp_data, expData);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_rsp_valid", rsp_valid, 1);
    checkOutput("release_no_grant", req_ready, 4'b0000);
    tick();
    @(negedge clk);
    checkOutput("after_hs_busy", busy, 0);
    checkOutput("after_hs_rsp_valid", rsp_valid, 0);
    checkOutput("after_hs_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();

    // reset while in EXEC
    applyStimulus(4'b1000, 8'($urandom), 8'($urandom), 12'($urandom), 1'b1);
    tick();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    checkResetOutputs();
    tick();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("no_rsp_after_reset", rsp_valid, 0);
    end
    tick();
    applyStimulus(4'b1111, 8'($urandom), 8'($urandom), 12'($urandom), 1'b1);
    @(negedge clk);
    checkOutput("post_reset_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();

`ifdef ALU_ARBITER_STATS_EN
    for (int i = 0; i < 260; i++) doOp(4'($urandom_range(1, 15)));
    @(negedge clk);
    checkOutput("op_count_sat", op_count, 8'd255);
`endif

    tick();
    checkOutput("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters; this revision SHALL support only the value 4.
REQ-002 Port clk, input, 1, sole clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port req_valid, input, 4, per-requester operation request; bit i is requester i.
REQ-005 Port req_ready, output, 4, one-hot grant and accept strobe.
REQ-006 Port req_a, input, 8, packed 2-bit operand A; requester i occupies [2i+1:2i].
REQ-007 Port req_b, input, 8, packed 2-bit operand B, same packing as req_a.
REQ-008 Port req_sel, input, 12, packed 3-bit opcode; requester i occupies [3i+2:3i].
REQ-009 Port alu_a, output, 2, operand A to the shared 2-bit arithmetic unit.
REQ-010 Port alu_b, output, 2, operand B to the shared unit.
REQ-011 Port alu_sel, output, 3, opcode to the shared unit.
REQ-012 Port alu_out, input, 3, signed result from the shared unit, combinational from alu_a/alu_b/alu_sel.
REQ-013 Port rsp_valid, output, 1, result available.
REQ-014 Port rsp_ready, input, 1, consumer accepts the result.
REQ-015 Port rsp_id, output, 2, index of the requester that owns rsp_data.
REQ-016 Port rsp_data, output, 3, captured signed result.
REQ-017 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-019 In IDLE with any req_valid bit set, req_ready SHALL combinationally assert for one winner only: the first valid index at or after rr_ptr, searching upward modulo 4.
REQ-020 On the accepting edge (req_valid[g] & req_ready[g]), the block SHALL latch that requester's a, b, sel and the index g, and SHALL move to EXEC.
REQ-021 req_ready SHALL be all zeros in EXEC and RESP, and in IDLE when req_valid is 0.
REQ-022 alu_a, alu_b and alu_sel SHALL be driven from the latched registers in every state; opcodes are passed unmodified, with no decode.
REQ-023 At the end of EXEC, alu_out SHALL be captured into rsp_data and g into rsp_id; the FSM SHALL then move to RESP.
REQ-024 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL hold stable until rsp_ready is sampled high.
REQ-025 On the edge where rsp_valid and rsp_ready are both high: FSM returns to IDLE, rr_ptr becomes (g+1) mod 4, and rsp_valid drops.
REQ-026 Latency: accept on edge N SHALL give rsp_valid high after edge N+1; maximum throughput is one operation every 3 cycles.
REQ-027 A new request SHALL NOT be accepted in the RESP cycle in which the response completes.
REQ-028 If rsp_ready is held low, the block SHALL stall in RESP indefinitely without losing data.
REQ-029 If a requester deasserts req_valid before it is granted, it SHALL NOT be granted and no state SHALL change.
REQ-030 Simultaneous requests SHALL be resolved by round-robin only; with continuous requests, every requester SHALL be served within 4 operations.

Reset
REQ-031 While rst_n is low, independent of clk: state is IDLE, rr_ptr is 0, and all latched operand registers are 0.
REQ-032 While rst_n is low: alu_a, alu_b, alu_sel, rsp_id, rsp_data, rsp_valid, req_ready and busy are all 0.
REQ-033 Reset asserted mid-operation SHALL discard the in-flight operation; no response SHALL be produced for it after reset releases.

Configuration
REQ-034 With macro ALU_ARBITER_STATS_EN defined, the block SHALL add output op_count (8 bits, reset 0).
REQ-035 op_count SHALL increment on each response handshake and saturate at 255.
REQ-036 Without ALU_ARBITER_STATS_EN, the op_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Single request: req_valid=0001, a=10, b=10, sel=000, ALU model gives 100, rsp_ready=1 -> req_ready=0001 at cycle 0; rsp_valid at cycle 2 with rsp_id=0 and rsp_data=100.
REQ-038 Continuous request pressure: req_valid=1111 held, rsp_ready=1 -> grant order is 0,1,2,3,0; each grant is 3 cycles apart.
REQ-039 Response stall: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_id stable; req_ready=0000 throughout; release -> handshake completes in 1 cycle.
REQ-040 Pointer resume: after serving requester 2, req_valid=0101 -> requester 0 is granted next (pointer at 3, wraps to 0).
REQ-041 Reset mid-op: rst_n pulsed low while in EXEC -> all outputs 0 immediately, no rsp_valid after release, next grant goes to requester 0.
REQ-042 With ALU_ARBITER_STATS_EN: 260 completed operations -> op_count=255.
